// File: rtl/codeword_tx_framer_if.sv
// rtl/codeword_tx_framer_if.sv - codeword write handshake between encoder and framer
interface codeword_tx_framer_if #(
    parameter int CW_WIDTH = 12
);
    logic                in_valid;
    logic [CW_WIDTH-1:0] in_data;
    logic                in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/codeword_tx_framer.sv
// rtl/codeword_tx_framer.sv - buffers codewords and serialises each as preamble, codeword, gap
// with a per-bit sample phase for the modulator.
module codeword_tx_framer #(
    parameter int CW_WIDTH        = 12,
    parameter int DEPTH           = 16,
    parameter int SAMPLES_PER_BIT = 256,
    parameter int PREAMBLE_BITS   = 8,
    parameter int GAP_BITS        = 2,
    localparam int PH_W           = $clog2(SAMPLES_PER_BIT),
    localparam int LVL_W          = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   arst,
    codeword_tx_framer_if.slave    in_if,
    input  logic                   en,
    input  logic                   clr_ovf,
    output logic                   tx_bit,
    output logic [PH_W-1:0]        tx_phase,
    output logic                   sym_strobe,
    output logic                   tx_active,
    output logic [LVL_W-1:0]       level,
    output logic                   overflow
);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int MAX_A    = (PREAMBLE_BITS > CW_WIDTH) ? PREAMBLE_BITS : CW_WIDTH;
    localparam int MAX_BITS = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
    localparam int CNT_W    = $clog2(MAX_BITS);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, GAP} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic [CW_WIDTH-1:0] shreg_q, shreg_d;
    logic [CW_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]    level_q;
    logic                overflow_q;
    logic                wr_en, pop, bit_end, fifo_empty;
    logic                tx_bit_d, tx_active_d, sym_strobe_d;

    assign in_if.in_ready = (level_q != LVL_W'(DEPTH));
    assign wr_en          = in_if.in_valid && in_if.in_ready;
    assign fifo_empty     = (level_q == '0);
    assign bit_end        = en && (state_q != IDLE) && (phase_q == PH_W'(SAMPLES_PER_BIT - 1));
    assign level          = level_q;
    assign overflow       = overflow_q;
    assign tx_phase       = phase_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= in_if.in_data;
    end

    // A refused write still sets overflow even if the FSM pops in the same cycle.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
            if (in_if.in_valid && !in_if.in_ready) overflow_q <= 1'b1;
            else if (clr_ovf)                      overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            phase_q    <= '0;
            shreg_q    <= '0;
            tx_bit     <= 1'b0;
            tx_active  <= 1'b0;
            sym_strobe <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            phase_q    <= phase_d;
            shreg_q    <= shreg_d;
            tx_bit     <= tx_bit_d;
            tx_active  <= tx_active_d;
            sym_strobe <= sym_strobe_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        pop       = 1'b0;
        if (en && state_q != IDLE) phase_d = phase_q + PH_W'(1);
        case (state_q)
            IDLE: begin
                if (en && !fifo_empty) begin
                    pop       = 1'b1;
                    state_d   = PREAMBLE;
                    bit_cnt_d = '0;
                    phase_d   = '0;
                    shreg_d   = mem[rd_ptr_q];
                end
            end
            PREAMBLE: begin
                if (bit_end) begin
                    if (bit_cnt_q == CNT_W'(PREAMBLE_BITS - 1)) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q << 1;
                    if (bit_cnt_q == CNT_W'(CW_WIDTH - 1)) begin
                        state_d   = GAP;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (bit_cnt_q == CNT_W'(GAP_BITS - 1)) begin
                        bit_cnt_d = '0;
                        // Back-to-back: next preamble starts on the very next sample.
                        if (!fifo_empty) begin
                            pop     = 1'b1;
                            state_d = PREAMBLE;
                            shreg_d = mem[rd_ptr_q];
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_active_d  = (state_d != IDLE);
        sym_strobe_d = en && tx_active_d && (phase_d == '0);
        tx_bit_d     = 1'b0;
        case (state_d)
            PREAMBLE: tx_bit_d = ~bit_cnt_d[0];
            DATA:     tx_bit_d = shreg_d[CW_WIDTH-1];
            default:  tx_bit_d = 1'b0;
        endcase
    end
endmodule

// File: tb/tb_codeword_tx_framer.sv
// tb/tb_codeword_tx_framer.sv - directed bench with a frame-level reference model
module tb_codeword_tx_framer;
    localparam int CW = 12;
    localparam int DEPTH = 4;
    localparam int SPB = 4;
    localparam int FRAME_SAMPLES = (8 + CW + 2) * SPB;

    logic       clk = 1'b0;
    logic       arst, en, clr_ovf;
    logic       tx_bit, sym_strobe, tx_active, overflow;
    logic [1:0] tx_phase;
    logic [2:0] level;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    codeword_tx_framer_if #(.CW_WIDTH(CW)) in_if ();

    codeword_tx_framer #(
        .CW_WIDTH(CW), .DEPTH(DEPTH), .SAMPLES_PER_BIT(SPB),
        .PREAMBLE_BITS(8), .GAP_BITS(2)
    ) dut (
        .clk(clk), .arst(arst), .in_if(in_if), .en(en), .clr_ovf(clr_ovf),
        .tx_bit(tx_bit), .tx_phase(tx_phase), .sym_strobe(sym_strobe),
        .tx_active(tx_active), .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a frame is a 22-bit vector {preamble, codeword, gap} walked by a sample index.
    logic [CW-1:0] mq[$];
    logic [21:0]   mframe;
    int            midx;
    bit            mact, mstb, movf;

    always @(posedge clk or posedge arst) begin
        if (arst) begin
            mq.delete();
            mact = 1'b0; midx = 0; mstb = 1'b0; movf = 1'b0; mframe = '0;
        end else begin
            int pre;
            pre = mq.size();
            if (in_if.in_valid && pre == DEPTH) movf = 1'b1;
            else if (clr_ovf)                   movf = 1'b0;
            mstb = 1'b0;
            if (en) begin
                if (mact) begin
                    midx++;
                    if (midx == FRAME_SAMPLES) begin mact = 1'b0; midx = 0; end
                end
                if (!mact && pre != 0) begin
                    mframe = {8'b10101010, mq.pop_front(), 2'b00};
                    mact = 1'b1;
                    midx = 0;
                end
                mstb = mact && (midx % SPB == 0);
            end
            if (in_if.in_valid && pre != DEPTH) mq.push_back(in_if.in_data);
        end
    end

    always @(negedge clk) begin
        if (chk_on && !arst) begin
            check("tx_active", 32'(tx_active), 32'(mact));
            check("tx_bit", 32'(tx_bit), mact ? 32'(mframe[21 - midx / SPB]) : 32'd0);
            check("tx_phase", 32'(tx_phase), mact ? 32'(midx % SPB) : 32'd0);
            check("sym_strobe", 32'(sym_strobe), 32'(mstb));
            check("level", 32'(level), 32'(mq.size()));
            check("in_ready", 32'(in_if.in_ready), 32'(mq.size() != DEPTH));
            check("overflow", 32'(overflow), 32'(movf));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1; en = 1'b0; clr_ovf = 1'b0;
        in_if.in_valid = 1'b0; in_if.in_data = '0;
        tick(); tick();
        #3;
        check("rst_level", 32'(level), 32'd0);
        check("rst_in_ready", 32'(in_if.in_ready), 32'd1);
        check("rst_tx_active", 32'(tx_active), 32'd0);
        check("rst_tx_bit", 32'(tx_bit), 32'd0);
        check("rst_tx_phase", 32'(tx_phase), 32'd0);
        check("rst_sym_strobe", 32'(sym_strobe), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        arst = 1'b0;
        chk_on = 1'b1;
        tick();
    endtask

    // Observe until tx_active falls; act counts active cycles with en high.
    task automatic run_frame(input bit toggle, input int limit, output int first,
                             output int act, output int nstb, output logic [63:0] bits);
        bit seen;
        seen = 1'b0; first = -1; act = 0; nstb = 0; bits = '0;
        for (int c = 0; c < limit; c++) begin
            tick();
            en = (!toggle || c < 40) ? 1'b1 : c[0];
            in_if.in_valid = 1'b0;
            #3;
            if (tx_active) begin
                if (!seen) first = c;
                seen = 1'b1;
                if (en) act++;
                if (sym_strobe) begin
                    bits = {bits[62:0], tx_bit};
                    nstb++;
                end
            end else if (seen) begin
                break;
            end
        end
    endtask

    initial begin
        int first, act, nstb;
        logic [63:0] bits;

        // 1: single frame of 0xA5C
        do_reset();
        en = 1'b1; in_if.in_valid = 1'b1; in_if.in_data = 12'hA5C;
        tick();
        in_if.in_valid = 1'b0;
        #3;
        check("t1_level_after_write", 32'(level), 32'd1);
        check("t1_idle_before_pop", 32'(tx_active), 32'd0);
        run_frame(1'b0, 300, first, act, nstb, bits);
        check("t1_latency", 32'(first), 32'd0);
        check("t1_active_cycles", 32'(act), 32'd88);
        check("t1_strobes", 32'(nstb), 32'd22);
        check("t1_bits", 32'(bits[21:0]), 32'(22'b10101010_101001011100_00));

        // 2: fill with en=0, fifth write overflows
        en = 1'b0;
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_if.in_data = 12'(12'h123 * (i + 1));
            tick();
            #3;
            if (i == 3) begin
                check("t2_level_full", 32'(level), 32'd4);
                check("t2_in_ready_full", 32'(in_if.in_ready), 32'd0);
                check("t2_no_ovf_yet", 32'(overflow), 32'd0);
            end
        end
        check("t2_ovf_set", 32'(overflow), 32'd1);
        check("t2_level_held", 32'(level), 32'd4);
        in_if.in_valid = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        #3;
        check("t2_ovf_cleared", 32'(overflow), 32'd0);

        // 6: write while full coinciding with a pop
        en = 1'b1; in_if.in_valid = 1'b1; in_if.in_data = 12'h555;
        #1;
        check("t6_refused", 32'(in_if.in_ready), 32'd0);
        tick();
        in_if.in_data = 12'h666;
        #3;
        check("t6_level_after_pop", 32'(level), 32'd3);
        check("t6_ovf", 32'(overflow), 32'd1);
        check("t6_ready_again", 32'(in_if.in_ready), 32'd1);
        tick();
        in_if.in_valid = 1'b0;
        #3;
        check("t6_accepted", 32'(level), 32'd4);

        // 5: reset mid-DATA with 3 words queued
        do_reset();
        in_if.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_if.in_data = 12'(12'h0F1 + 12'(i * 12'h210));
            tick();
        end
        in_if.in_valid = 1'b0; en = 1'b1;
        repeat (40) tick();
        #1;
        check("t5_queued", 32'(level), 32'd3);
        arst = 1'b1;
        #1;
        check("t5_abort_active", 32'(tx_active), 32'd0);
        check("t5_abort_bit", 32'(tx_bit), 32'd0);
        check("t5_abort_level", 32'(level), 32'd0);
        check("t5_abort_ready", 32'(in_if.in_ready), 32'd1);
        tick();
        arst = 1'b0;
        run_frame(1'b0, 100, first, act, nstb, bits);
        check("t5_no_frames", 32'(act), 32'd0);

        // 3: two queued words go out back-to-back
        do_reset();
        in_if.in_valid = 1'b1; in_if.in_data = 12'hA5C;
        tick();
        in_if.in_data = 12'h3F0;
        tick();
        in_if.in_valid = 1'b0;
        run_frame(1'b0, 400, first, act, nstb, bits);
        check("t3_continuous", 32'(act), 32'd176);
        check("t3_strobes", 32'(nstb), 32'd44);
        check("t3_bits", 32'(bits[43:22]), 32'(22'b10101010_101001011100_00));
        check("t3_bits2", 32'(bits[21:0]), 32'(22'b10101010_001111110000_00));

        // 4: en toggling every cycle from mid-DATA
        do_reset();
        en = 1'b1; in_if.in_valid = 1'b1; in_if.in_data = 12'hA5C;
        tick();
        in_if.in_valid = 1'b0;
        run_frame(1'b1, 400, first, act, nstb, bits);
        check("t4_enabled_cycles", 32'(act), 32'd88);
        check("t4_strobes", 32'(nstb), 32'd22);
        check("t4_bits", 32'(bits[21:0]), 32'(22'b10101010_101001011100_00));

        en = 1'b0;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "timeout");
    end
endmodule
